// File: rtl/sram_arbiter.sv
// Two-port arbiter for a shared asynchronous 16-bit SRAM. Reads win by default, and a starvation
// counter forces a waiting write. Each access holds the strobes for a fixed time, then one turnaround cycle.
module sram_arbiter #(
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_req,
   input  logic [19:0] rd_addr,
   output logic        rd_ack,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   input  logic        wr_req,
   input  logic [19:0] wr_addr,
   input  logic [15:0] wr_data,
   output logic        wr_ack,
   output logic        wr_done,
   output logic        addr_sel,
   output logic [19:0] sram_addr,
   input  logic [15:0] sram_dq_in,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD      = 2'd1,
      WR      = 2'd2,
      RECOVER = 2'd3
   } state_t;

   localparam logic [3:0] ACC_LAST   = 4'(ACCESS_CYCLES);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [3:0]  starve_reg, starve_next;

   logic        rd_ack_reg, rd_ack_next;
   logic        wr_ack_reg, wr_ack_next;
   logic        rd_valid_reg, rd_valid_next;
   logic        wr_done_reg, wr_done_next;
   logic        addr_sel_reg, addr_sel_next;
   logic [19:0] sram_addr_reg, sram_addr_next;
   logic [15:0] dq_out_reg, dq_out_next;
   logic [15:0] rd_data_reg, rd_data_next;
   logic        dq_oe_reg, dq_oe_next;
   logic        ce_n_reg, ce_n_next;
   logic        oe_n_reg, oe_n_next;
   logic        we_n_reg, we_n_next;

   logic        grant_rd, grant_wr;
   logic        last_beat;
   logic [1:0]  be_n;

   // Requests are only looked at in IDLE; a pending write wins once the reads have used up their quota.
   always_comb begin
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      if (state_reg == IDLE) begin
         if (rd_req && wr_req) begin
            if (starve_reg == STARVE_MAX)
               grant_wr = 1'b1;
            else
               grant_rd = 1'b1;
         end else if (rd_req) begin
            grant_rd = 1'b1;
         end else if (wr_req) begin
            grant_wr = 1'b1;
         end
      end
   end

   assign last_beat = (cnt_reg == ACC_LAST);

   // State register plus all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         starve_reg    <= 4'd0;
         rd_ack_reg    <= 1'b0;
         wr_ack_reg    <= 1'b0;
         rd_valid_reg  <= 1'b0;
         wr_done_reg   <= 1'b0;
         addr_sel_reg  <= 1'b0;
         sram_addr_reg <= 20'd0;
         dq_out_reg    <= 16'd0;
         rd_data_reg   <= 16'd0;
         dq_oe_reg     <= 1'b0;
         ce_n_reg      <= 1'b1;
         oe_n_reg      <= 1'b1;
         we_n_reg      <= 1'b1;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         starve_reg    <= starve_next;
         rd_ack_reg    <= rd_ack_next;
         wr_ack_reg    <= wr_ack_next;
         rd_valid_reg  <= rd_valid_next;
         wr_done_reg   <= wr_done_next;
         addr_sel_reg  <= addr_sel_next;
         sram_addr_reg <= sram_addr_next;
         dq_out_reg    <= dq_out_next;
         rd_data_reg   <= rd_data_next;
         dq_oe_reg     <= dq_oe_next;
         ce_n_reg      <= ce_n_next;
         oe_n_reg      <= oe_n_next;
         we_n_reg      <= we_n_next;
      end
   end

   // Next state and access-beat counter; the counter reads 1 in the first strobe cycle
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (grant_rd) begin
               state_next = RD;
               cnt_next   = 4'd1;
            end else if (grant_wr) begin
               state_next = WR;
               cnt_next   = 4'd1;
            end
         end
         RD, WR: begin
            if (last_beat) begin
               state_next = RECOVER;
               cnt_next   = 4'd0;
            end else begin
               cnt_next = cnt_reg + 4'd1;
            end
         end
         RECOVER: state_next = IDLE;
         default: begin
            state_next = IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   // Starvation counter only tracks reads granted over the head of a waiting write
   always_comb begin
      starve_next = starve_reg;
      if (!wr_req)
         starve_next = 4'd0;
      else if (grant_wr)
         starve_next = 4'd0;
      else if (grant_rd && (starve_reg < STARVE_MAX))
         starve_next = starve_reg + 4'd1;
   end

   // Output decode: strobes follow the state being entered so they line up with it after the register
   always_comb begin
      ce_n_next      = !((state_next == RD) || (state_next == WR));
      oe_n_next      = (state_next != RD);
      we_n_next      = (state_next != WR);
      dq_oe_next     = (state_next == WR);
      rd_ack_next    = grant_rd;
      wr_ack_next    = grant_wr;
      rd_valid_next  = (state_reg == RD) && last_beat;
      wr_done_next   = (state_reg == WR) && last_beat;
      addr_sel_next  = addr_sel_reg;
      sram_addr_next = sram_addr_reg;
      dq_out_next    = dq_out_reg;
      rd_data_next   = rd_data_reg;
      if (grant_rd) begin
         addr_sel_next  = 1'b0;
         sram_addr_next = rd_addr;
      end else if (grant_wr) begin
         addr_sel_next  = 1'b1;
         sram_addr_next = wr_addr;
         dq_out_next    = wr_data;
      end
      if ((state_reg == RD) && last_beat)
         rd_data_next = sram_dq_in;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_byte_en
         assign be_n[gi] = ce_n_reg;
      end
   endgenerate

   assign rd_ack      = rd_ack_reg;
   assign wr_ack      = wr_ack_reg;
   assign rd_valid    = rd_valid_reg;
   assign wr_done     = wr_done_reg;
   assign rd_data     = rd_data_reg;
   assign addr_sel    = addr_sel_reg;
   assign sram_addr   = sram_addr_reg;
   assign sram_dq_out = dq_out_reg;
   assign sram_dq_oe  = dq_oe_reg;
   assign sram_ce_n   = ce_n_reg;
   assign sram_oe_n   = oe_n_reg;
   assign sram_we_n   = we_n_reg;
   assign sram_ub_n   = be_n[1];
   assign sram_lb_n   = be_n[0];

endmodule
